shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Command-driven controller that sequences an 8-bit left-shift register (load/shift/data_in/data_out datapath) on behalf of a single requester. It accepts a byte plus a shift amount over a valid/ready handshake, then drives one load pulse followed by exactly that many shift pulses. It returns the register's resulting value over a second valid/ready handshake, flagged against an internally computed expected value. It sits between the command source and the shift-register instance; the register itself is external.

## Interface
- WIDTH, 8, data width of the shift register and command data
- AMT_W, 3, width of shift amount; amounts 0..2^AMT_W-1
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state and outputs to reset values immediately
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command; reset 0
- cmd_data  in  WIDTH  value to load
- cmd_amount  in  AMT_W  number of left shifts after load
- sr_load  out  1  load strobe to shift register; reset 0
- sr_shift  out  1  shift strobe to shift register; reset 0
- sr_data_in  out  WIDTH  load value to shift register; reset 0
- sr_data_out  in  WIDTH  current shift-register contents
- res_valid  out  1  result present; reset 0
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  result value; reset 0
- res_err  out  1  result differs from expected; reset 0
- busy  out  1  high in every state except IDLE; reset 0

## Operation
- States: IDLE, LOAD, SHIFT, RESP. Reset state IDLE.
- IDLE: cmd_ready=1, except the first cycle after reset release, when it is 0 because cmd_ready is registered. On cmd_valid&&cmd_ready, capture cmd_data, cmd_amount, and expected = (cmd_data << cmd_amount) truncated to WIDTH. Go to LOAD.
- LOAD: one cycle. sr_load=1, sr_shift=0, sr_data_in=captured data. If amount==0 go to RESP, else load the remaining-shift counter with amount and go to SHIFT.
- SHIFT: sr_shift=1, sr_load=0 each cycle. Decrement the counter each cycle. When the counter reaches 1 in the current cycle, go to RESP. This gives exactly `amount` shift cycles.
- RESP: sr_load=sr_shift=0, so the register holds. res_valid=1. res_data=sr_data_out, combinational pass-through, stable while held. res_err = (sr_data_out != expected). On res_valid&&res_ready go to IDLE.
- sr_load and sr_shift are never high in the same cycle.
- sr_data_in holds the last captured value outside LOAD.
- cmd_valid while busy is ignored; no command is captured until IDLE.
- A command is never dropped; a result is never lost under backpressure.
- Reset at any time, including mid-SHIFT or RESP: abort immediately. Outputs go to reset values and no partial result is issued. The shift register contents are not this block's responsibility.

## Timing
- Accept at edge E0 → LOAD in cycle after E0. The register loads at E1. Shifts occur at E2..E(1+amount). res_valid rises after edge E(1+amount).
- Latency accept→res_valid = amount+1 edges: 1 for amount 0, 8 for amount 7.
- Result accepted at edge Ek → IDLE after Ek, with cmd_ready=1 in that same cycle. The next command can be accepted at E(k+1).
- Minimum command spacing is amount+3 cycles with res_ready tied high.
- Outputs sr_load, sr_shift, cmd_ready, res_valid and busy are state-decoded from registered state, with no combinational path from inputs.
- Exception: res_data and res_err depend combinationally on sr_data_out.

## Test plan
- Reset then cmd 0x65, amount 1, res_ready=1: one sr_load cycle with sr_data_in=0x65, then one sr_shift cycle. res_valid 2 edges after accept with res_data=0xCA, res_err=0.
- Cmd 0x65, amount 0: sr_load only, no sr_shift pulse. res_data=0x65 after 1 edge, res_err=0.
- Cmd 0x81, amount 7: exactly 7 consecutive sr_shift cycles. res_data=0x80, res_err=0. Then back-to-back cmd 0xFF, amount 3 accepted the cycle after the response → 0xF8.
- Backpressure: res_ready=0 for 5 cycles with cmd_valid held high. res_valid and res_data stay stable, cmd_ready stays 0, and the second command is accepted only after the response handshake.
- reset pulled low during the 3rd shift of amount 5: all outputs 0 immediately, no res_valid. After release, cmd_ready=1 one cycle later and the next command 0x01, amount 2 yields 0x04.
- Faulty register model that shifts in 1 instead of 0: cmd 0x65, amount 1 → res_data=0xCB, res_err=1.

Source files
------------

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command-driven load/shift sequencer for an external left-shift register
//
// Purpose: accepts {data, amount} on a valid/ready command channel, issues one
// load strobe and then `amount` shift strobes to an external shift register,
// and returns the register contents on a valid/ready result channel. The
// result carries an error flag when the contents differ from (data << amount).
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_data, cmd_amount payload
//   sr_load, sr_shift   strobes to the shift register; sr_data_in load value
//   sr_data_out         shift register contents
//   res_valid/ready     result handshake; res_data, res_err payload
//   busy                high whenever a command is in flight
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [AMT_W-1:0] cmd_amount,
  output logic             sr_load,
  output logic             sr_shift,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_cmd_ready;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_exp;
  logic [AMT_W-1:0] r_amt;
  logic [AMT_W-1:0] r_cnt;
  logic             w_accept;

  // r_cmd_ready is high only while r_state is IDLE, so no state qualifier needed.
  assign w_accept = cmd_valid && r_cmd_ready;

  always_comb begin
    w_next    = r_state;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_err   = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_LOAD;
      end
      S_LOAD: begin
        sr_load = 1'b1;
        w_next  = (r_amt == '0) ? S_RESP : S_SHIFT;
      end
      S_SHIFT: begin
        sr_shift = 1'b1;
        // Counter holds shifts remaining including this one.
        if (r_cnt == AMT_W'(1)) w_next = S_RESP;
      end
      S_RESP: begin
        res_valid = 1'b1;
        res_data  = sr_data_out;
        res_err   = (sr_data_out != r_exp);
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_data      <= '0;
      r_exp       <= '0;
      r_amt       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_next;
      // Registered from next state: high in the same cycle IDLE is re-entered,
      // low in the first cycle after reset release.
      r_cmd_ready <= (w_next == S_IDLE);
      if (r_state == S_IDLE && w_accept) begin
        r_data <= cmd_data;
        r_amt  <= cmd_amount;
        r_exp  <= cmd_data << cmd_amount;
      end
      if (r_state == S_LOAD) begin
        r_cnt <= r_amt;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - AMT_W'(1);
      end
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign sr_data_in = r_data;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed scoreboard bench for shift_sequencer
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic [2:0] cmd_amount = '0;
  logic       sr_load;
  logic       sr_shift;
  logic [7:0] sr_data_in;
  logic [7:0] sr_data_out;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic       res_err;
  logic       busy;

  logic       fault = 1'b0;
  logic [7:0] sr_q = '0;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_amount (cmd_amount),
    .sr_load    (sr_load),
    .sr_shift   (sr_shift),
    .sr_data_in (sr_data_in),
    .sr_data_out(sr_data_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .busy       (busy)
  );

  // External shift register; `fault` makes it shift in 1 instead of 0.
  always @(posedge clk) begin
    if (sr_load) sr_q <= sr_data_in;
    else if (sr_shift) sr_q <= {sr_q[6:0], fault};
  end
  assign sr_data_out = sr_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] d, input logic [2:0] a);
    int         w;
    logic [7:0] e;
    logic [15:0] m;
    exp_t       x;
    cmd_data   = d;
    cmd_amount = a;
    cmd_valid  = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    e = d << a;
    m = (16'h1 << a) - 16'h1;
    if (fault) e = e | m[7:0];
    x.d = e;
    x.e = fault && (a != 3'd0);
    q.push_back(x);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_res(input logic [7:0] d, input logic [2:0] a, input int bp);
    int   cyc;
    int   nl;
    int   ns;
    exp_t x;
    cyc = 0; nl = 0; ns = 0;
    while (res_valid !== 1'b1 && cyc < 50) begin
      if (sr_load === 1'b1) begin
        nl++;
        check("sr_data_in", sr_data_in, d);
      end
      if (sr_shift === 1'b1) ns++;
      check("load_shift_excl", sr_load & sr_shift, 0);
      check("busy_inflight", busy, 1);
      @(posedge clk); #1;
      cyc++;
    end
    check("res_valid_timeout", res_valid, 1);
    check("latency", cyc, a + 1);
    check("load_pulses", nl, 1);
    check("shift_pulses", ns, a);
    check("queue_nonempty", q.size() > 0, 1);
    if (q.size() > 0) begin
      x = q.pop_front();
      check("res_data", res_data, x.d);
      check("res_err", res_err, x.e);
      if (bp > 0) begin
        res_ready = 1'b0;
        repeat (bp) begin
          @(posedge clk); #1;
          check("bp_res_valid", res_valid, 1);
          check("bp_res_data", res_data, x.d);
          check("bp_cmd_ready", cmd_ready, 0);
          check("bp_no_strobe", sr_load | sr_shift, 0);
        end
        res_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    check("post_res_valid", res_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_busy", busy, 0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_sr_load", sr_load, 0);
    check("rst_sr_shift", sr_shift, 0);
    check("rst_sr_data_in", sr_data_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    check("rel_cmd_ready0", cmd_ready, 0);
    @(posedge clk); #1;
    check("rel_cmd_ready1", cmd_ready, 1);

    // Basic amount 1 and amount 0
    send_cmd(8'h65, 3'd1);
    get_res(8'h65, 3'd1, 0);
    send_cmd(8'h65, 3'd0);
    get_res(8'h65, 3'd0, 0);

    // Full-range amount, then back-to-back command
    send_cmd(8'h81, 3'd7);
    get_res(8'h81, 3'd7, 0);
    send_cmd(8'hFF, 3'd3);
    get_res(8'hFF, 3'd3, 0);

    // Backpressure with the next command held valid throughout
    send_cmd(8'h12, 3'd2);
    cmd_data   = 8'h34;
    cmd_amount = 3'd1;
    cmd_valid  = 1'b1;
    get_res(8'h12, 3'd2, 5);
    send_cmd(8'h34, 3'd1);
    get_res(8'h34, 3'd1, 0);

    // Reset during the third shift of amount 5
    send_cmd(8'h33, 3'd5);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_shift", sr_shift, 1);
    reset = 1'b0;
    #1;
    check("abort_cmd_ready", cmd_ready, 0);
    check("abort_sr_load", sr_load, 0);
    check("abort_sr_shift", sr_shift, 0);
    check("abort_sr_data_in", sr_data_in, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_res_data", res_data, 0);
    check("abort_res_err", res_err, 0);
    check("abort_busy", busy, 0);
    q.delete();
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_hold_res_valid", res_valid, 0);
    end
    reset = 1'b1;
    check("abort_rel_cmd_ready0", cmd_ready, 0);
    @(posedge clk); #1;
    check("abort_rel_cmd_ready1", cmd_ready, 1);
    send_cmd(8'h01, 3'd2);
    get_res(8'h01, 3'd2, 0);

    // Faulty register shifting in ones
    fault = 1'b1;
    send_cmd(8'h65, 3'd1);
    get_res(8'h65, 3'd1, 0);
    fault = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
